spi_flash_responder: RTL

Synthesizable SPI-mode-0 flash responder. It emulates the command subset the bootloader's SPI master issues (wake, JEDEC ID, read, status, deep power-down) on top of a simple byte-read memory port. It is used as the far end of the flash interface in FPGA-in-the-loop and simulation builds that replace AT25SF081. SPI pins are oversampled by clk_i; there is no SCK clock domain.

---
 rtl/spi_flash_responder.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/spi_flash_responder.sv
// spi_flash_responder
//   SPI mode-0 flash responder. It serves wake (0xAB), deep power-down (0xB9),
//   JEDEC ID (0x9F), status (0x05) and read (0x03) from a simple byte-read
//   memory port. SPI pins are oversampled by clk_i.
// Ports:
//   clk_i, rstn_i       system clock, synchronous active-low reset
//   sck_i, csn_i, sdi_i SPI clock, chip select (active-low), MOSI (async)
//   sdo_o, sdo_oe_o     MISO and its output enable
//   mem_addr_o          byte read address
//   mem_rd_o            one-cycle read strobe
//   mem_data_i          read data, valid MEM_LAT cycles after the strobe
//   pd_o                deep power-down flag
module spi_flash_responder #(
    parameter int unsigned ADDR_BITS = 20,
    parameter logic [23:0] JEDEC_ID  = 24'h1F8501,
    parameter int unsigned MEM_LAT   = 2
) (
    input  logic                 clk_i,
    input  logic                 rstn_i,
    input  logic                 sck_i,
    input  logic                 csn_i,
    input  logic                 sdi_i,
    output logic                 sdo_o,
    output logic                 sdo_oe_o,
    output logic [ADDR_BITS-1:0] mem_addr_o,
    output logic                 mem_rd_o,
    input  logic [7:0]           mem_data_i,
    output logic                 pd_o
);

    typedef enum logic [2:0] {
        S_IDLE, S_CMD, S_ADDR, S_READ, S_ID, S_STATUS, S_IGNORE
    } state_t;

    state_t r_state, w_next;

    logic r_sck_meta, r_sck_sync, r_sck_prev;
    logic r_csn_meta, r_csn_sync, r_csn_prev;
    logic r_sdi_meta, r_sdi_sync;

    logic [2:0]           r_bitcnt;
    logic [6:0]           r_rx;
    logic [15:0]          r_addr;
    logic [1:0]           r_idx;
    logic [7:0]           r_tx;
    logic                 r_sdo;
    logic                 r_oe;
    logic [ADDR_BITS-1:0] r_mem_addr;
    logic                 r_mem_rd;
    logic [2:0]           r_lat;
    logic                 r_pd;

    logic       w_sck_rise, w_sck_fall, w_csn_fall, w_csn_hi;
    logic       w_byte_done, w_resp;
    logic [7:0] w_byte;

    assign w_sck_rise  = r_sck_sync & ~r_sck_prev;
    assign w_sck_fall  = ~r_sck_sync & r_sck_prev;
    assign w_csn_fall  = ~r_csn_sync & r_csn_prev;
    assign w_csn_hi    = r_csn_sync;
    assign w_byte      = {r_rx, r_sdi_sync};
    assign w_byte_done = w_sck_rise && (r_bitcnt == 3'd7) && (r_state != S_IDLE);
    assign w_resp      = (r_state == S_READ) || (r_state == S_ID) || (r_state == S_STATUS);

    always_ff @(posedge clk_i) begin
        if (!rstn_i) r_state <= S_IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (w_csn_hi) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: if (w_csn_fall) w_next = S_CMD;
                S_CMD: begin
                    if (w_byte_done) begin
                        if (r_pd) begin
                            w_next = S_IGNORE;
                        end else begin
                            case (w_byte)
                                8'h9F:   w_next = S_ID;
                                8'h05:   w_next = S_STATUS;
                                8'h03:   w_next = S_ADDR;
                                default: w_next = S_IGNORE;
                            endcase
                        end
                    end
                end
                S_ADDR: if (w_byte_done && (r_idx == 2'd2)) w_next = S_READ;
                default: w_next = r_state;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            r_sck_meta <= 1'b0; r_sck_sync <= 1'b0; r_sck_prev <= 1'b0;
            r_csn_meta <= 1'b1; r_csn_sync <= 1'b1; r_csn_prev <= 1'b1;
            r_sdi_meta <= 1'b0; r_sdi_sync <= 1'b0;
            r_bitcnt   <= '0;
            r_rx       <= '0;
            r_addr     <= '0;
            r_idx      <= '0;
            r_tx       <= '1;
            r_sdo      <= 1'b1;
            r_oe       <= 1'b0;
            r_mem_addr <= '0;
            r_mem_rd   <= 1'b0;
            r_lat      <= '0;
            r_pd       <= 1'b0;
        end else begin
            r_sck_meta <= sck_i; r_sck_sync <= r_sck_meta; r_sck_prev <= r_sck_sync;
            r_csn_meta <= csn_i; r_csn_sync <= r_csn_meta; r_csn_prev <= r_csn_sync;
            r_sdi_meta <= sdi_i; r_sdi_sync <= r_sdi_meta;

            r_mem_rd <= 1'b0;
            if (r_lat != 3'd0) r_lat <= r_lat - 3'd1;

            if (w_csn_hi) begin
                r_bitcnt <= '0;
                r_idx    <= '0;
                r_oe     <= 1'b0;
                r_sdo    <= 1'b1;
                r_lat    <= '0;
            end else begin
                if (w_sck_rise && (r_state != S_IDLE)) begin
                    r_bitcnt <= r_bitcnt + 3'd1;
                    r_rx     <= w_byte[6:0];
                end

                if ((r_state == S_CMD) && w_byte_done) begin
                    r_idx <= '0;
                    if (w_byte == 8'hAB) begin
                        r_pd <= 1'b0;
                    end else if (!r_pd) begin
                        if (w_byte == 8'hB9) r_pd <= 1'b1;
                        if (w_byte == 8'h9F) r_tx <= JEDEC_ID[23:16];
                        if (w_byte == 8'h05) r_tx <= 8'h00;
                    end
                end

                if ((r_state == S_ADDR) && w_byte_done) begin
                    r_idx  <= r_idx + 2'd1;
                    r_addr <= {r_addr[7:0], w_byte};
                    if (r_idx == 2'd2) begin
                        // SPI address is 24 bits; only the low ADDR_BITS reach memory
                        r_mem_addr <= ADDR_BITS'({r_addr, w_byte});
                        r_mem_rd   <= 1'b1;
                        r_lat      <= 3'(MEM_LAT + 1);
                    end
                end

                if ((r_state == S_READ) && w_byte_done) begin
                    r_mem_addr <= r_mem_addr + ADDR_BITS'(1);
                    r_mem_rd   <= 1'b1;
                    r_lat      <= 3'(MEM_LAT + 1);
                end

                if ((r_state == S_ID) && w_byte_done) begin
                    case (r_idx)
                        2'd0:    begin r_tx <= JEDEC_ID[15:8]; r_idx <= 2'd1; end
                        2'd1:    begin r_tx <= JEDEC_ID[7:0];  r_idx <= 2'd2; end
                        default: r_tx <= 8'hFF;
                    endcase
                end

                if ((r_state == S_STATUS) && w_byte_done) r_tx <= 8'h00;

                if (w_resp && w_sck_fall) begin
                    r_sdo <= r_tx[7];
                    r_tx  <= {r_tx[6:0], 1'b1};
                    r_oe  <= 1'b1;
                end

                // r_lat == 1 marks the cycle in which mem_data_i is valid;
                // the minimum sck half-period keeps it clear of any shift
                if (r_lat == 3'd1) r_tx <= mem_data_i;
            end
        end
    end

    assign sdo_o      = r_sdo;
    assign sdo_oe_o   = r_oe;
    assign mem_addr_o = r_mem_addr;
    assign mem_rd_o   = r_mem_rd;
    assign pd_o       = r_pd;

endmodule
